fetch_entry_queue: RTL and testbench



---
 rtl/fetch_entry_queue.sv | 100 ++++++++++
 tb/tb_fetch_entry_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_entry_queue.sv
// Circular fetch-entry queue between the instruction realigner and decode.
// Accepts up to two program-ordered slots per cycle and presents one head entry per cycle.
module fetch_entry_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned VLEN  = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic [1:0]               push_valid_i,
   input  logic [2*VLEN-1:0]        push_addr_i,
   input  logic [63:0]              push_instr_i,
   input  logic [1:0]               push_ex_i,
   output logic                     push_ready_o,
   output logic                     fetch_entry_valid_o,
   output logic [VLEN-1:0]          fetch_entry_addr_o,
   output logic [31:0]              fetch_entry_instr_o,
   output logic                     fetch_entry_ex_o,
   input  logic                     fetch_entry_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [VLEN-1:0]  addr_mem_r  [DEPTH];
   logic [31:0]      instr_mem_r [DEPTH];
   logic [DEPTH-1:0] ex_mem_r;
   logic [PW-1:0]    rptr_r;
   logic [PW-1:0]    wptr_r;
   logic [PW-1:0]    rptr_n_s;
   logic [PW-1:0]    wptr_n_s;
   logic [PW-1:0]    wptr_p1_s;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_n_s;
   logic             push_ready_s;
   logic             push0_s;
   logic             push1_s;
   logic             pop_s;

   // Room for a full pair is judged from occupancy alone, never from pointers.
   assign push_ready_s = (CW'(DEPTH) - count_r) >= CW'(2);
   assign push0_s      = push_ready_s & push_valid_i[0];
   // Anything after a faulting slot is discarded.
   assign push1_s      = push0_s & push_valid_i[1] & ~push_ex_i[0];
   assign pop_s        = (count_r != CW'(0)) & fetch_entry_ready_i;
   assign wptr_p1_s    = wptr_r + PW'(1);

   // Next pointers and occupancy; a flush overrides any push or pop.
   always_comb begin
      rptr_n_s  = rptr_r;
      wptr_n_s  = wptr_r;
      count_n_s = count_r;
      if (flush_i) begin
         rptr_n_s  = PW'(0);
         wptr_n_s  = PW'(0);
         count_n_s = CW'(0);
      end else begin
         rptr_n_s  = rptr_r + PW'(pop_s);
         wptr_n_s  = wptr_r + PW'(push0_s) + PW'(push1_s);
         count_n_s = count_r + CW'(push0_s) + CW'(push1_s) - CW'(pop_s);
      end
   end

   // Pointer, occupancy and entry storage registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rptr_r   <= PW'(0);
         wptr_r   <= PW'(0);
         count_r  <= CW'(0);
         ex_mem_r <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_mem_r[i]  <= '0;
            instr_mem_r[i] <= 32'h0000_0000;
         end
      end else begin
         rptr_r  <= rptr_n_s;
         wptr_r  <= wptr_n_s;
         count_r <= count_n_s;
         if (!flush_i && push0_s) begin
            addr_mem_r[wptr_r]  <= push_addr_i[VLEN-1:0];
            instr_mem_r[wptr_r] <= push_instr_i[31:0];
            ex_mem_r[wptr_r]    <= push_ex_i[0];
         end
         if (!flush_i && push1_s) begin
            addr_mem_r[wptr_p1_s]  <= push_addr_i[2*VLEN-1:VLEN];
            instr_mem_r[wptr_p1_s] <= push_instr_i[63:32];
            ex_mem_r[wptr_p1_s]    <= push_ex_i[1];
         end
      end
   end

   assign push_ready_o        = push_ready_s;
   assign fetch_entry_valid_o = (count_r != CW'(0));
   assign fetch_entry_addr_o  = addr_mem_r[rptr_r];
   assign fetch_entry_instr_o = instr_mem_r[rptr_r];
   assign fetch_entry_ex_o    = ex_mem_r[rptr_r];
   assign count_o             = count_r;

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Self-checking bench for fetch_entry_queue: directed vector table, async reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_fetch_entry_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned VLEN  = 64;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         flush_i;
   logic [1:0]   push_valid_i;
   logic [127:0] push_addr_i;
   logic [63:0]  push_instr_i;
   logic [1:0]   push_ex_i;
   logic         push_ready_o;
   logic         fetch_entry_valid_o;
   logic [63:0]  fetch_entry_addr_o;
   logic [31:0]  fetch_entry_instr_o;
   logic         fetch_entry_ex_o;
   logic         fetch_entry_ready_i;
   logic [2:0]   count_o;

   int n_cmp = 0;
   int n_err = 0;

   fetch_entry_queue #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .push_valid_i(push_valid_i), .push_addr_i(push_addr_i),
      .push_instr_i(push_instr_i), .push_ex_i(push_ex_i),
      .push_ready_o(push_ready_o), .fetch_entry_valid_o(fetch_entry_valid_o),
      .fetch_entry_addr_o(fetch_entry_addr_o), .fetch_entry_instr_o(fetch_entry_instr_o),
      .fetch_entry_ex_o(fetch_entry_ex_o), .fetch_entry_ready_i(fetch_entry_ready_i),
      .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       flush;
      logic [1:0] pv;
      logic [1:0] ex;
      logic       rdy;
      int         cnt;
      logic       vld;
      logic       prdy;
      int         hk;
      int         hs;
      logic       hex;
   } vec_t;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] instr;
      logic        ex;
   } ent_t;

   vec_t tbl[24];
   ent_t model_q[$];

   function automatic logic [63:0] va(int k, int s);
      return 64'h0000_0000_8000_0000 + 64'(k) * 64'd16 + 64'(s) * 64'd4;
   endfunction

   function automatic logic [31:0] vi(int k, int s);
      if (k == 0 && s == 0) return 32'h0000_0013;
      return 32'hA000_0000 + 32'(k) * 32'd2 + 32'(s);
   endfunction

   function automatic vec_t mk(logic f, logic [1:0] pv, logic [1:0] ex, logic rdy,
                               int cnt, logic vld, logic prdy, int hk, int hs, logic hex);
      vec_t v;
      v.flush = f; v.pv = pv; v.ex = ex; v.rdy = rdy; v.cnt = cnt;
      v.vld = vld; v.prdy = prdy; v.hk = hk; v.hs = hs; v.hex = hex;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive vector k for one clock edge and check the state it leaves behind.
   task automatic apply_vec(int k, vec_t v);
      flush_i             = v.flush;
      push_valid_i        = v.pv;
      push_ex_i           = v.ex;
      fetch_entry_ready_i = v.rdy;
      push_addr_i         = {va(k, 1), va(k, 0)};
      push_instr_i        = {vi(k, 1), vi(k, 0)};
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d count", k), 64'(count_o), 64'(v.cnt));
      chk($sformatf("v%0d valid", k), 64'(fetch_entry_valid_o), 64'(v.vld));
      chk($sformatf("v%0d push_ready", k), 64'(push_ready_o), 64'(v.prdy));
      if (v.vld) begin
         chk($sformatf("v%0d addr", k), fetch_entry_addr_o, va(v.hk, v.hs));
         chk($sformatf("v%0d instr", k), 64'(fetch_entry_instr_o), 64'(vi(v.hk, v.hs)));
         chk($sformatf("v%0d ex", k), 64'(fetch_entry_ex_o), 64'(v.hex));
      end
   endtask

   task automatic idle_inputs();
      flush_i = 1'b0; push_valid_i = 2'b00; push_ex_i = 2'b00;
      fetch_entry_ready_i = 1'b0; push_addr_i = '0; push_instr_i = 64'd0;
   endtask

   initial begin
      tbl[0]  = mk(1'b0, 2'b01, 2'b00, 1'b0, 1, 1'b1, 1'b1,  0, 0, 1'b0);
      tbl[1]  = mk(1'b0, 2'b00, 2'b00, 1'b1, 0, 1'b0, 1'b1,  0, 0, 1'b0);
      tbl[2]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 2, 1'b1, 1'b1,  2, 0, 1'b0);
      tbl[3]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 4, 1'b1, 1'b0,  2, 0, 1'b0);
      tbl[4]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 4, 1'b1, 1'b0,  2, 0, 1'b0);
      tbl[5]  = mk(1'b0, 2'b00, 2'b00, 1'b1, 3, 1'b1, 1'b0,  2, 1, 1'b0);
      tbl[6]  = mk(1'b0, 2'b00, 2'b00, 1'b1, 2, 1'b1, 1'b1,  3, 0, 1'b0);
      tbl[7]  = mk(1'b0, 2'b00, 2'b00, 1'b1, 1, 1'b1, 1'b1,  3, 1, 1'b0);
      tbl[8]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 3, 1'b1, 1'b0,  3, 1, 1'b0);
      tbl[9]  = mk(1'b0, 2'b00, 2'b00, 1'b1, 2, 1'b1, 1'b1,  8, 0, 1'b0);
      tbl[10] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1, 1'b1, 1'b1,  8, 1, 1'b0);
      tbl[11] = mk(1'b0, 2'b00, 2'b00, 1'b1, 0, 1'b0, 1'b1,  0, 0, 1'b0);
      tbl[12] = mk(1'b0, 2'b11, 2'b01, 1'b0, 1, 1'b1, 1'b1, 12, 0, 1'b1);
      tbl[13] = mk(1'b0, 2'b00, 2'b00, 1'b1, 0, 1'b0, 1'b1,  0, 0, 1'b0);
      tbl[14] = mk(1'b0, 2'b10, 2'b00, 1'b0, 0, 1'b0, 1'b1,  0, 0, 1'b0);
      tbl[15] = mk(1'b0, 2'b11, 2'b00, 1'b0, 2, 1'b1, 1'b1, 15, 0, 1'b0);
      tbl[16] = mk(1'b0, 2'b11, 2'b00, 1'b1, 3, 1'b1, 1'b0, 15, 1, 1'b0);
      tbl[17] = mk(1'b1, 2'b01, 2'b00, 1'b1, 0, 1'b0, 1'b1,  0, 0, 1'b0);
      tbl[18] = mk(1'b0, 2'b01, 2'b00, 1'b1, 1, 1'b1, 1'b1, 18, 0, 1'b0);
      tbl[19] = mk(1'b0, 2'b11, 2'b00, 1'b1, 2, 1'b1, 1'b1, 19, 0, 1'b0);
      tbl[20] = mk(1'b1, 2'b00, 2'b00, 1'b1, 0, 1'b0, 1'b1,  0, 0, 1'b0);
      tbl[21] = mk(1'b0, 2'b11, 2'b10, 1'b0, 2, 1'b1, 1'b1, 21, 0, 1'b0);
      tbl[22] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1, 1'b1, 1'b1, 21, 1, 1'b1);
      tbl[23] = mk(1'b0, 2'b00, 2'b00, 1'b1, 0, 1'b0, 1'b1,  0, 0, 1'b0);

      // Reset values.
      idle_inputs();
      rst_i = 1'b1;
      #12;
      chk("rst valid", 64'(fetch_entry_valid_o), 64'd0);
      chk("rst push_ready", 64'(push_ready_o), 64'd1);
      chk("rst count", 64'(count_o), 64'd0);
      chk("rst addr", fetch_entry_addr_o, 64'd0);
      chk("rst instr", 64'(fetch_entry_instr_o), 64'd0);
      chk("rst ex", 64'(fetch_entry_ex_o), 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      for (int k = 0; k < 24; k++) apply_vec(k, tbl[k]);

      // Async reset in the middle of a burst with three entries queued.
      apply_vec(30, mk(1'b0, 2'b11, 2'b00, 1'b0, 2, 1'b1, 1'b1, 30, 0, 1'b0));
      apply_vec(31, mk(1'b0, 2'b01, 2'b00, 1'b0, 3, 1'b1, 1'b0, 30, 0, 1'b0));
      idle_inputs();
      #3;
      rst_i = 1'b1;
      #1;
      chk("async valid", 64'(fetch_entry_valid_o), 64'd0);
      chk("async count", 64'(count_o), 64'd0);
      chk("async push_ready", 64'(push_ready_o), 64'd1);
      chk("async addr", fetch_entry_addr_o, 64'd0);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      apply_vec(0, tbl[0]);
      apply_vec(1, tbl[1]);

      // Randomized traffic against the reference queue, starting empty.
      model_q.delete();
      for (int c = 0; c < 3000; c++) begin
         logic        m_prdy;
         logic [63:0] a0, a1;
         logic [31:0] i0, i1;
         chk("rnd count", 64'(count_o), 64'(model_q.size()));
         chk("rnd valid", 64'(fetch_entry_valid_o), 64'(model_q.size() != 0));
         m_prdy = (DEPTH - model_q.size()) >= 2;
         chk("rnd push_ready", 64'(push_ready_o), 64'(m_prdy));
         if (model_q.size() != 0) begin
            chk("rnd addr", fetch_entry_addr_o, model_q[0].addr);
            chk("rnd instr", 64'(fetch_entry_instr_o), 64'(model_q[0].instr));
            chk("rnd ex", 64'(fetch_entry_ex_o), 64'(model_q[0].ex));
         end
         a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
         i0 = $urandom; i1 = $urandom;
         flush_i             = ($urandom_range(0, 31) == 0);
         push_valid_i        = 2'($urandom_range(0, 3));
         push_ex_i           = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         fetch_entry_ready_i = 1'($urandom_range(0, 1));
         push_addr_i         = {a1, a0};
         push_instr_i        = {i1, i0};
         if (flush_i) begin
            model_q.delete();
         end else begin
            if (model_q.size() != 0 && fetch_entry_ready_i) void'(model_q.pop_front());
            if (m_prdy && push_valid_i[0]) begin
               model_q.push_back('{addr: a0, instr: i0, ex: push_ex_i[0]});
               if (push_valid_i[1] && !push_ex_i[0])
                  model_q.push_back('{addr: a1, instr: i1, ex: push_ex_i[1]});
            end
         end
         @(posedge clk_i);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
